// File: rtl/aes256_inv_key_scheduler_pkg.sv
// Shared definitions for the reverse AES-256 key schedule:
// sizes, FSM encoding, round constants and S-box arithmetic.
package aes256_inv_key_scheduler_pkg;

    localparam int AES_256_KEY_LENGTH = 256;
    localparam int AES_BLOCK_SIZE = 128;
    localparam int AES_WORD_SIZE = 32;
    localparam int AES_256_ROUND_KEYS = 15;
    localparam int AES_256_NUMBER_OF_ROUNDS = AES_256_ROUND_KEYS - 1;
    localparam int AES_ROUND_W = $clog2(AES_256_ROUND_KEYS);

    localparam logic [7:0] AES_RCON_01 = 8'h01;
    localparam logic [7:0] AES_RCON_02 = 8'h02;
    localparam logic [7:0] AES_RCON_03 = 8'h04;
    localparam logic [7:0] AES_RCON_04 = 8'h08;
    localparam logic [7:0] AES_RCON_05 = 8'h10;
    localparam logic [7:0] AES_RCON_06 = 8'h20;
    localparam logic [7:0] AES_RCON_07 = 8'h40;

    typedef enum logic [0:0] {IDLE, STREAM} aes_inv_ks_state_t;

    typedef logic [AES_WORD_SIZE-1:0] aes_word_t;
    typedef logic [AES_BLOCK_SIZE-1:0] aes_block_t;
    typedef logic [AES_ROUND_W-1:0] aes_round_t;

    function automatic logic [7:0] aes_rcon(input logic [2:0] idx);
        logic [7:0] rc;
        unique case (idx)
            3'd1: rc = AES_RCON_01;
            3'd2: rc = AES_RCON_02;
            3'd3: rc = AES_RCON_03;
            3'd4: rc = AES_RCON_04;
            3'd5: rc = AES_RCON_05;
            3'd6: rc = AES_RCON_06;
            3'd7: rc = AES_RCON_07;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // Inverse as x^254 (zero maps to zero), then the FIPS-197 affine map.
    function automatic logic [7:0] aes_sbox_calc(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] inv;
        s = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            inv = gf_mul(inv, s);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes256_inv_key_scheduler_if.sv
// Load and stream handshakes of the reverse key scheduler.
interface aes256_inv_key_scheduler_if;
    import aes256_inv_key_scheduler_pkg::*;

    logic in_valid;
    logic in_ready;
    logic [AES_256_KEY_LENGTH-1:0] last_key;
    logic out_valid;
    logic out_ready;
    aes_block_t out_key;
    aes_round_t out_round;
    logic out_last;

    modport slave (
        input in_valid, last_key, out_ready,
        output in_ready, out_valid, out_key, out_round, out_last
    );

    modport master (
        output in_valid, last_key, out_ready,
        input in_ready, out_valid, out_key, out_round, out_last
    );

endinterface

// File: rtl/aes256_key_expansion_reverse_step.sv
// One inverse AES-256 expansion step: K[r-2] from K[r] and K[r-1].
module aes256_key_expansion_reverse_step
    import aes256_inv_key_scheduler_pkg::*;
(
    input  aes_round_t round_number,
    input  aes_block_t hi_key,
    input  aes_block_t lo_key,
    output aes_block_t prev_key
);

    aes_word_t a0, a1, a2, a3;
    aes_word_t b3;
    aes_word_t sub_in;
    aes_word_t sub_out;
    aes_word_t f;

    assign a0 = hi_key[127:96];
    assign a1 = hi_key[95:64];
    assign a2 = hi_key[63:32];
    assign a3 = hi_key[31:0];
    assign b3 = lo_key[31:0];

    // Even rounds see RotWord+Rcon, odd rounds plain SubWord.
    assign sub_in = round_number[0] ? b3 : {b3[23:0], b3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte (sub_in[8*i +: 8]),
            .out_byte(sub_out[8*i +: 8])
        );
    end

    assign f = sub_out ^ (round_number[0] ? 32'h0
                          : {aes_rcon(round_number[3:1]), 24'h0});

    assign prev_key = {a0 ^ f, a1 ^ a0, a2 ^ a1, a3 ^ a2};

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, single byte, purely combinational.
module aes_sbox
    import aes256_inv_key_scheduler_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = aes_sbox_calc(in_byte);

endmodule

// File: rtl/aes256_inv_key_scheduler.sv
// Streams AES-256 round keys 14..0 from the last two round keys,
// rebuilding each earlier key on the fly.
module aes256_inv_key_scheduler
    import aes256_inv_key_scheduler_pkg::*;
(
    input logic clk,
    input logic rst_n,
    aes256_inv_key_scheduler_if.slave bus
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_STREAM = STREAM;

    logic [0:0] state;
    aes_block_t hi;
    aes_block_t lo;
    aes_block_t prev;
    aes_round_t round;

    aes256_key_expansion_reverse_step u_step (
        .round_number(round),
        .hi_key      (hi),
        .lo_key      (lo),
        .prev_key    (prev)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
            round <= '0;
        end else if (state == ST_IDLE) begin
            if (bus.in_valid) begin
                hi    <= bus.last_key[AES_BLOCK_SIZE-1:0];
                lo    <= bus.last_key[AES_256_KEY_LENGTH-1:AES_BLOCK_SIZE];
                round <= AES_ROUND_W'(AES_256_NUMBER_OF_ROUNDS);
                state <= ST_STREAM;
            end
        end else if (bus.out_ready) begin
            // lo takes a don't-care step below round 2; it is never shown.
            hi <= lo;
            lo <= prev;
            if (round == '0) state <= ST_IDLE;
            else round <= round - 1'b1;
        end
    end

    assign bus.in_ready  = state == ST_IDLE;
    assign bus.out_valid = state == ST_STREAM;
    assign bus.out_key   = hi;
    assign bus.out_round = round;
    assign bus.out_last  = (round == '0) && (state == ST_STREAM);

endmodule

// File: tb/tb_aes256_inv_key_scheduler.sv
// Scoreboard bench: forward AES-256 expansion as reference, randomized
// keys, backpressure, overlap, mid-stream reset and step unit checks.
`timescale 1ns/1ps
module tb_aes256_inv_key_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    bit bp = 1'b0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;

    aes256_inv_key_scheduler_if bus ();

    aes256_inv_key_scheduler dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [3:0]   u_round;
    logic [127:0] u_hi;
    logic [127:0] u_lo;
    logic [127:0] u_prev;

    aes256_key_expansion_reverse_step u_step (
        .round_number(u_round),
        .hi_key      (u_hi),
        .lo_key      (u_lo),
        .prev_key    (u_prev)
    );

    always #5 clk = ~clk;

    logic [2047:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [31:0] w [60];

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tab[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    task automatic expand(input logic [255:0] key);
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc << 1;
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
    endtask

    function automatic logic [127:0] rk(input int r);
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic patch(input int idx, input logic [127:0] key);
        beat_t b;
        b = exp_q[idx];
        b.key = key;
        exp_q[idx] = b;
    endtask

    task automatic load(input logic [255:0] key);
        beat_t b;
        expand(key);
        for (int r = 14; r >= 0; r--) begin
            b.round = 4'(r);
            b.key = rk(r);
            exp_q.push_back(b);
        end
        chk("in_ready_idle", 128'(bus.in_ready), 128'd1);
        bus.in_valid = 1'b1;
        bus.last_key = {rk(13), rk(14)};
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left %0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // Out_ready driver: random when bp is set, otherwise held high.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stall holds.
    initial begin
        logic stalled;
        logic [127:0] st_key;
        logic [3:0] st_round;
        stalled = 1'b0;
        st_key = '0;
        st_round = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (!bus.out_valid || bus.out_key !== st_key
                        || bus.out_round !== st_round) begin
                        errors++;
                        $display("FAIL stall_hold got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                                 bus.out_valid, bus.out_round, bus.out_key,
                                 st_round, st_key);
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                st_key = bus.out_key;
                st_round = bus.out_round;
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat got r=%0d k=%h want none",
                                 bus.out_round, bus.out_key);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (bus.out_round !== mon_e.round
                            || bus.out_key !== mon_e.key
                            || bus.out_last !== (mon_e.round == 4'd0)) begin
                            errors++;
                            $display("FAIL beat got r=%0d k=%h l=%b want r=%0d k=%h l=%b",
                                     bus.out_round, bus.out_key, bus.out_last,
                                     mon_e.round, mon_e.key, mon_e.round == 4'd0);
                        end
                    end
                end
            end
        end
    end

    logic [255:0] fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    task automatic patch_fips();
        patch(0, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        patch(13, 128'h101112131415161718191a1b1c1d1e1f);
        patch(14, 128'h000102030405060708090a0b0c0d0e0f);
    endtask

    initial begin
        int cyc;
        logic [255:0] k1;
        logic [255:0] k2;
        bus.in_valid = 1'b0;
        bus.last_key = '0;
        u_round = '0;
        u_hi = '0;
        u_lo = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_last", 128'(bus.out_last), 128'd0);
        chk("rst_out_round", 128'(bus.out_round), 128'd0);
        chk("rst_out_key", bus.out_key, 128'd0);
        rst_n = 1'b1;
        tick();

        load(fips_key);
        patch_fips();
        chk("first_valid", 128'(bus.out_valid), 128'd1);
        chk("first_round", 128'(bus.out_round), 128'd14);
        drain(100, cyc);
        chk("fips_no_gap", 128'(cyc), 128'd15);
        chk("in_ready_after_last", 128'(bus.in_ready), 128'd1);
        chk("idle_out_valid", 128'(bus.out_valid), 128'd0);

        load(256'h0);
        patch(12, 128'h62636363626363636263636362636363);
        patch(13, 128'h0);
        patch(14, 128'h0);
        drain(100, cyc);
        chk("zero_no_gap", 128'(cyc), 128'd15);

        bp = 1'b1;
        load(fips_key);
        patch_fips();
        drain(600, cyc);
        bp = 1'b0;
        repeat (2) tick();

        k1 = rand_key();
        k2 = rand_key();
        load(k1);
        repeat (3) tick();
        chk("stream_in_ready", 128'(bus.in_ready), 128'd0);
        bus.in_valid = 1'b1;
        bus.last_key = k2;
        tick();
        bus.in_valid = 1'b0;
        drain(100, cyc);
        chk("reload_in_ready", 128'(bus.in_ready), 128'd1);
        load(k2);
        drain(100, cyc);
        chk("reload_no_gap", 128'(cyc), 128'd15);

        load(rand_key());
        cyc = 0;
        while (!(bus.out_valid && bus.out_round == 4'd7) && cyc < 40) begin
            tick();
            cyc++;
        end
        if (cyc >= 40) begin
            checks++;
            errors++;
            $display("FAIL wait_round7 got timeout want round 7");
        end
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst_out_key", bus.out_key, 128'd0);
        chk("midrst_out_round", 128'(bus.out_round), 128'd0);
        repeat (3) begin
            tick();
            chk("midrst_quiet", 128'(bus.out_valid), 128'd0);
        end
        load(rand_key());
        chk("restart_round", 128'(bus.out_round), 128'd14);
        drain(100, cyc);
        chk("restart_no_gap", 128'(cyc), 128'd15);

        for (int n = 0; n < 1000; n++) begin
            bp = n >= 900;
            load(rand_key());
            drain(600, cyc);
            if (!bp) chk("rand_no_gap", 128'(cyc), 128'd15);
        end
        bp = 1'b0;

        for (int n = 0; n < 20; n++) begin
            expand(rand_key());
            for (int r = 2; r <= 14; r++) begin
                u_round = 4'(r);
                u_hi = rk(r);
                u_lo = rk(r - 1);
                #1;
                chk($sformatf("step_r%0d", r), u_prev, rk(r - 2));
            end
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
